// File: rtl/pb_gpi_debounce.sv
// 8-bit general purpose input conditioner: two-flop synchronizer, independent
// per-bit debounce counters with per-bit bypass, and registered rise/fall pulses.
module pb_gpi_debounce #(
  parameter int DB_CYCLES = 1000,
  parameter int CNT_W     = 16
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [7:0] gpi_raw,
  input  logic [7:0] db_enable,
  output logic [7:0] gpi,
  output logic [7:0] rise_o,
  output logic [7:0] fall_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [7:0] sync1_q;
  logic [7:0] s_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync1_q <= '0;
      s_q     <= '0;
    end else begin
      sync1_q <= gpi_raw;
      s_q     <= sync1_q;
    end
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_bit
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             lvl_q;
    logic             lvl_d;
    logic             rise_q;
    logic             fall_q;

    // Any cycle where the synchronized level agrees with the accepted one
    // restarts the stability count; acceptance also restarts it.
    always_comb begin
      cnt_d = '0;
      lvl_d = lvl_q;
      if (!db_enable[gi]) begin
        lvl_d = s_q[gi];
      end else if (s_q[gi] == lvl_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        lvl_d = s_q[gi];
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
        cnt_q  <= '0;
        lvl_q  <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        lvl_q  <= lvl_d;
        rise_q <= lvl_d & ~lvl_q;
        fall_q <= ~lvl_d & lvl_q;
      end
    end

    assign gpi[gi]    = lvl_q;
    assign rise_o[gi] = rise_q;
    assign fall_o[gi] = fall_q;
  end

endmodule

// File: tb/tb_pb_gpi_debounce.sv
// Bench for pb_gpi_debounce: a DB_CYCLES=4 and a DB_CYCLES=1 instance share the
// stimulus and are checked against a sliding-window reference model.
module tb_pb_gpi_debounce;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] raw = 8'h00;
  logic [7:0] en = 8'hFF;
  logic [7:0] g4, r4, f4, g1, r1, f1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pb_gpi_debounce #(.DB_CYCLES(4), .CNT_W(16)) dut4 (
    .clk_i(clk), .rst_n_i(rst_n), .gpi_raw(raw), .db_enable(en),
    .gpi(g4), .rise_o(r4), .fall_o(f4)
  );

  pb_gpi_debounce #(.DB_CYCLES(1), .CNT_W(3)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .gpi_raw(raw), .db_enable(en),
    .gpi(g1), .rise_o(r1), .fall_o(f1)
  );

  // Model state per instance (0: DB=4, 1: DB=1) and a history of the last 8
  // edges: whether the edge was out of reset, the synchronized level, the
  // enable and the accepted level seen by that edge.
  bit [7:0] m_sync1[2], m_s[2], m_gpi[2], m_rise[2], m_fall[2];
  bit       hv[2][8];
  bit [7:0] hs[2][8], he[2][8], hg[2][8];

  // A new level is accepted once the last DB edges all saw the same
  // synchronized level, differing from the accepted one, with debounce enabled.
  task automatic model_edge(input logic [7:0] r, input logic [7:0] e, input logic rn);
    for (int m = 0; m < 2; m++) begin
      int db;
      bit [7:0] ng;
      bit ok;
      db = (m == 0) ? 4 : 1;
      for (int k = 7; k > 0; k--) begin
        hv[m][k] = hv[m][k-1];
        hs[m][k] = hs[m][k-1];
        he[m][k] = he[m][k-1];
        hg[m][k] = hg[m][k-1];
      end
      if (!rn) begin
        hv[m][0] = 1'b0;
        m_sync1[m] = '0; m_s[m] = '0; m_gpi[m] = '0; m_rise[m] = '0; m_fall[m] = '0;
      end else begin
        hv[m][0] = 1'b1;
        hs[m][0] = m_s[m];
        he[m][0] = e;
        hg[m][0] = m_gpi[m];
        ng = m_gpi[m];
        for (int i = 0; i < 8; i++) begin
          if (!e[i]) begin
            ng[i] = m_s[m][i];
          end else begin
            ok = (m_s[m][i] != m_gpi[m][i]);
            for (int k = 0; k < db; k++)
              if (!(hv[m][k] && he[m][k][i] && hs[m][k][i] == m_s[m][i] && hg[m][k][i] == m_gpi[m][i]))
                ok = 1'b0;
            if (ok) ng[i] = m_s[m][i];
          end
        end
        m_rise[m]  = ng & ~m_gpi[m];
        m_fall[m]  = ~ng & m_gpi[m];
        m_gpi[m]   = ng;
        m_s[m]     = m_sync1[m];
        m_sync1[m] = r;
      end
    end
  endtask

  task automatic step(input logic [7:0] r, input logic [7:0] e, input logic rn);
    raw = r;
    en = e;
    rst_n = rn;
    @(posedge clk);
    #1;
    model_edge(r, e, rn);
  endtask

  task automatic test_reset();
    $display("test_reset");
    for (int k = 0; k < 3; k++) begin
      step(8'($urandom), 8'hFF, 1'b0);
      total++;
      if ({g4, r4, f4, g1, r1, f1} !== 48'h0) begin
        bad++;
        $display("FAIL reset cyc=%0d got g4=%h r4=%h f4=%h g1=%h r1=%h f1=%h want all 00",
                 k, g4, r4, f4, g1, r1, f1);
      end
    end
  endtask

  task automatic test_rise();
    logic [7:0] eg4, er4, eg1, er1;
    $display("test_rise");
    for (int k = 0; k < 6; k++) step(8'h00, 8'hFF, 1'b1);
    step(8'h01, 8'hFF, 1'b1);
    for (int d = 1; d <= 6; d++) begin
      step(8'h01, 8'hFF, 1'b1);
      eg4 = (d >= 5) ? 8'h01 : 8'h00;
      er4 = (d == 5) ? 8'h01 : 8'h00;
      eg1 = (d >= 2) ? 8'h01 : 8'h00;
      er1 = (d == 2) ? 8'h01 : 8'h00;
      total++;
      if ({g4, r4, f4} !== {eg4, er4, 8'h00}) begin
        bad++;
        $display("FAIL rise_db4 N+%0d got g=%h r=%h f=%h want g=%h r=%h f=00", d, g4, r4, f4, eg4, er4);
      end
      total++;
      if ({g1, r1, f1} !== {eg1, er1, 8'h00}) begin
        bad++;
        $display("FAIL rise_db1 N+%0d got g=%h r=%h f=%h want g=%h r=%h f=00", d, g1, r1, f1, eg1, er1);
      end
    end
  endtask

  task automatic test_glitch();
    $display("test_glitch");
    for (int k = 0; k < 10; k++) step(8'h00, 8'hFF, 1'b1);
    for (int rep = 0; rep < 2; rep++) begin
      for (int c = 0; c < 11; c++) begin
        step((c < 3) ? 8'h08 : 8'h00, 8'hFF, 1'b1);
        total++;
        if ({g4, r4, f4} !== 24'h0) begin
          bad++;
          $display("FAIL glitch rep=%0d cyc=%0d got g=%h r=%h f=%h want 00 00 00", rep, c, g4, r4, f4);
        end
      end
    end
  endtask

  task automatic test_bypass();
    logic [7:0] eg, er;
    $display("test_bypass");
    for (int k = 0; k < 4; k++) step(8'h00, 8'h00, 1'b1);
    step(8'hA5, 8'h00, 1'b1);
    for (int d = 1; d <= 4; d++) begin
      step(8'hA5, 8'h00, 1'b1);
      eg = (d >= 2) ? 8'hA5 : 8'h00;
      er = (d == 2) ? 8'hA5 : 8'h00;
      total++;
      if ({g4, r4, f4, g1, r1, f1} !== {eg, er, 8'h00, eg, er, 8'h00}) begin
        bad++;
        $display("FAIL bypass N+%0d got g4=%h r4=%h f4=%h g1=%h r1=%h f1=%h want g=%h r=%h f=00",
                 d, g4, r4, f4, g1, r1, f1, eg, er);
      end
    end
  endtask

  task automatic test_fall();
    logic [7:0] eg, ef;
    $display("test_fall");
    for (int k = 0; k < 10; k++) step(8'hFF, 8'hFF, 1'b1);
    total++;
    if (g4 !== 8'hFF) begin
      bad++;
      $display("FAIL fall_setup got g=%h want FF", g4);
    end
    step(8'h00, 8'hFF, 1'b1);
    for (int d = 1; d <= 6; d++) begin
      step(8'h00, 8'hFF, 1'b1);
      eg = (d >= 5) ? 8'h00 : 8'hFF;
      ef = (d == 5) ? 8'hFF : 8'h00;
      total++;
      if ({g4, r4, f4} !== {eg, 8'h00, ef}) begin
        bad++;
        $display("FAIL fall N+%0d got g=%h r=%h f=%h want g=%h r=00 f=%h", d, g4, r4, f4, eg, ef);
      end
    end
  endtask

  task automatic test_reset_no_pulse();
    logic [7:0] eg4, er4, eg1, er1;
    $display("test_reset_no_pulse");
    for (int k = 0; k < 10; k++) step(8'hFF, 8'hFF, 1'b1);
    step(8'hFF, 8'hFF, 1'b0);
    total++;
    if ({g4, r4, f4, g1, r1, f1} !== 48'h0) begin
      bad++;
      $display("FAIL reset_from_ff got g4=%h r4=%h f4=%h g1=%h r1=%h f1=%h want all 00",
               g4, r4, f4, g1, r1, f1);
    end
    for (int d = 0; d <= 6; d++) begin
      step(8'hFF, 8'hFF, 1'b1);
      eg4 = (d >= 5) ? 8'hFF : 8'h00;
      er4 = (d == 5) ? 8'hFF : 8'h00;
      eg1 = (d >= 2) ? 8'hFF : 8'h00;
      er1 = (d == 2) ? 8'hFF : 8'h00;
      total++;
      if ({g4, r4, f4, g1, r1, f1} !== {eg4, er4, 8'h00, eg1, er1, 8'h00}) begin
        bad++;
        $display("FAIL post_reset R+%0d got g4=%h r4=%h f4=%h g1=%h r1=%h want g4=%h r4=%h g1=%h r1=%h",
                 d, g4, r4, f4, g1, r1, eg4, er4, eg1, er1);
      end
    end
  endtask

  task automatic test_reset_midcount();
    logic [7:0] eg, er;
    $display("test_reset_midcount");
    for (int k = 0; k < 10; k++) step(8'h00, 8'hFF, 1'b1);
    for (int k = 0; k < 3; k++) step(8'h01, 8'hFF, 1'b1);
    step(8'h01, 8'hFF, 1'b0);
    total++;
    if ({g4, r4, f4} !== 24'h0) begin
      bad++;
      $display("FAIL midcount_reset got g=%h r=%h f=%h want 00 00 00", g4, r4, f4);
    end
    for (int d = 0; d <= 6; d++) begin
      step(8'h01, 8'hFF, 1'b1);
      eg = (d >= 5) ? 8'h01 : 8'h00;
      er = (d == 5) ? 8'h01 : 8'h00;
      total++;
      if ({g4, r4, f4} !== {eg, er, 8'h00}) begin
        bad++;
        $display("FAIL midcount_resume R+%0d got g=%h r=%h f=%h want g=%h r=%h f=00", d, g4, r4, f4, eg, er);
      end
    end
  endtask

  task automatic test_independent();
    logic [7:0] eg, er;
    $display("test_independent");
    for (int k = 0; k < 10; k++) step(8'h00, 8'hFF, 1'b1);
    for (int e = 0; e <= 10; e++) begin
      step((e >= 2) ? 8'h81 : 8'h01, 8'hFF, 1'b1);
      eg = {(e >= 7) ? 1'b1 : 1'b0, 6'b0, (e >= 5) ? 1'b1 : 1'b0};
      er = {(e == 7) ? 1'b1 : 1'b0, 6'b0, (e == 5) ? 1'b1 : 1'b0};
      total++;
      if ({g4, r4, f4} !== {eg, er, 8'h00}) begin
        bad++;
        $display("FAIL independent N+%0d got g=%h r=%h f=%h want g=%h r=%h f=00", e, g4, r4, f4, eg, er);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] r, e;
    logic rn;
    int len;
    r = 8'h00;
    e = 8'hFF;
    for (int seg = 0; seg < 150; seg++) begin
      r = r ^ 8'($urandom);
      if ($urandom_range(0, 5) == 0) e = 8'($urandom);
      else if ($urandom_range(0, 3) == 0) e = 8'hFF;
      rn = ($urandom_range(0, 40) != 0);
      len = $urandom_range(1, 8);
      $display("seg %0d raw=%h en=%h rst_n=%0d len=%0d", seg, r, e, rn, len);
      for (int c = 0; c < len; c++) begin
        step(r, e, (c == 0) ? rn : 1'b1);
        total++;
        if ({g4, r4, f4} !== {m_gpi[0], m_rise[0], m_fall[0]}) begin
          bad++;
          $display("FAIL random_db4 seg=%0d cyc=%0d got g=%h r=%h f=%h want g=%h r=%h f=%h",
                   seg, c, g4, r4, f4, m_gpi[0], m_rise[0], m_fall[0]);
        end
        total++;
        if ({g1, r1, f1} !== {m_gpi[1], m_rise[1], m_fall[1]}) begin
          bad++;
          $display("FAIL random_db1 seg=%0d cyc=%0d got g=%h r=%h f=%h want g=%h r=%h f=%h",
                   seg, c, g1, r1, f1, m_gpi[1], m_rise[1], m_fall[1]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_rise();
    test_glitch();
    test_bypass();
    test_fall();
    test_reset_no_pulse();
    test_reset_midcount();
    test_independent();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pb_gpi_debounce.md
PB_GPI_DEBOUNCE -- requirements
Module: pb_gpi_debounce

Interface
REQ-001 The block SHALL have parameter DB_CYCLES, default 1000, giving the number of consecutive stable synchronized cycles required to accept a new input level.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of each per-bit debounce counter.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n_i, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port gpi_raw, input, 8 bits: asynchronous pin-level inputs.
REQ-006 The block SHALL have port db_enable, input, 8 bits: per-bit debounce enable; 0 = bypass debounce for that bit.
REQ-007 The block SHALL have port gpi, output, 8 bits: clean, synchronized, debounced levels feeding the general purpose input stage.
REQ-008 The block SHALL have port rise_o, output, 8 bits: one-cycle pulse per bit when gpi[i] goes 0->1.
REQ-009 The block SHALL have port fall_o, output, 8 bits: one-cycle pulse per bit when gpi[i] goes 1->0.

Function
REQ-010 Each bit SHALL pass through a two-flop synchronizer: sync1[i] <= gpi_raw[i]; s[i] <= sync1[i].
REQ-011 Each bit SHALL own an independent CNT_W-bit counter cnt[i]; bits SHALL NOT interact.
REQ-012 With db_enable[i]=1, each edge: if s[i]==gpi[i] -> cnt[i]<=0; else if cnt[i]==DB_CYCLES-1 -> gpi[i]<=s[i], cnt[i]<=0; else cnt[i]<=cnt[i]+1.
REQ-013 With db_enable[i]=0: gpi[i]<=s[i] every edge; cnt[i]<=0.
REQ-014 Latency, debounced: a raw level sampled into sync1 at edge N and held SHALL appear on gpi at edge N+1+DB_CYCLES.
REQ-015 Latency, bypass: a raw level sampled at edge N SHALL appear on gpi at edge N+2.
REQ-016 A mismatch interrupted by even one cycle of s[i]==gpi[i] SHALL clear cnt[i]; any glitch shorter than DB_CYCLES synchronized cycles SHALL NOT change gpi[i].
REQ-017 rise_o[i]/fall_o[i] SHALL be registered and asserted for exactly the one cycle following the edge on which gpi[i] changes; never both for the same bit in the same cycle.
REQ-018 Toggling db_enable[i] 1->0 mid-count SHALL discard the count; 0->1 SHALL start counting from 0.
REQ-019 The counter SHALL never exceed DB_CYCLES-1 and SHALL never wrap.
REQ-020 DB_CYCLES SHALL satisfy 1 <= DB_CYCLES <= 2^CNT_W-1; DB_CYCLES=1 SHALL give latency N+2, identical to bypass.
REQ-021 Simultaneous changes on several bits SHALL be processed in parallel; each bit SHALL update on its own schedule.

Reset
REQ-022 While rst_n_i=0 at a rising edge: sync1, s, gpi, rise_o, fall_o SHALL all be 8'h00, and every cnt SHALL be 0.
REQ-023 Reset asserted mid-count SHALL abort the count; no rise or fall pulse SHALL be generated by reset itself.
REQ-024 After reset release, an input held at 1 SHALL be accepted via the normal debounce path, producing rise_o.

Verification
REQ-025 DB_CYCLES=4, db_enable=FF, gpi_raw 00->01 at edge N -> gpi=01 at edge N+5; rise_o=01 for one cycle after that edge.
REQ-026 DB_CYCLES=4, bit 3 pulsed high for 3 cycles then low -> gpi stays 00; rise_o and fall_o stay 00; cnt[3] returns to 0.
REQ-027 db_enable=00, gpi_raw 00->A5 at edge N -> gpi=A5 at edge N+2; rise_o=A5 for one cycle.
REQ-028 DB_CYCLES=4, gpi=FF steady, gpi_raw->00 at edge N -> gpi=00 at edge N+5 with fall_o=FF for one cycle.
REQ-029 Mid-count reset: gpi_raw=01, rst_n_i=0 at edge N+3, released next edge -> all outputs 00, no pulse; gpi=01 five edges after the first post-reset sample.
REQ-030 Independent bits: bit 0 rises at N, bit 7 rises at N+2 (DB_CYCLES=4) -> gpi[0] at N+5, gpi[7] at N+7, separate rise_o pulses.
